// File: rtl/bsg_mul_rv_sequencer_if.sv
// bsg_mul_rv_sequencer_if: request/response bus between the sequencer (master) and the Booth multiplier (slave)
interface bsg_mul_rv_sequencer_if #(parameter int width_p = 64);
  logic [width_p-1:0]   mul_opA_o;
  logic [width_p-1:0]   mul_opB_o;
  logic                 mul_signed_o;
  logic                 mul_v_o;
  logic                 mul_ready_i;
  logic [2*width_p-1:0] mul_result_i;
  logic                 mul_v_i;
  logic                 mul_yumi_o;
  modport master (
    output mul_opA_o, mul_opB_o, mul_signed_o, mul_v_o, mul_yumi_o,
    input  mul_ready_i, mul_result_i, mul_v_i
  );
  modport slave (
    input  mul_opA_o, mul_opB_o, mul_signed_o, mul_v_o, mul_yumi_o,
    output mul_ready_i, mul_result_i, mul_v_i
  );
endinterface

// File: rtl/bsg_mul_rv_sequencer.sv
// bsg_mul_rv_sequencer: RISC-V MUL/MULH/MULHSU/MULHU sequencer around the radix-8 Booth multiplier; BSG_MUL_RV_WORD_EN adds word_i (MULW)
module bsg_mul_rv_sequencer #(parameter int width_p = 64) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  output logic                 ready_o,
  input  logic [1:0]           op_i,
  input  logic [width_p-1:0]   opA_i,
  input  logic [width_p-1:0]   opB_i,
`ifdef BSG_MUL_RV_WORD_EN
  input  logic                 word_i,
`endif
  output logic                 v_o,
  output logic [width_p-1:0]   result_o,
  input  logic                 yumi_i,
  bsg_mul_rv_sequencer_if.master mul_if
);
  typedef enum logic [2:0] {eIdle, eIssue, eWait, eFix, eDone} state_e;
  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [width_p-1:0] opA_q, opA_d, opB_q, opB_d, result_q, result_d;
  logic               mulw_q, mulw_d, mulw_in;
`ifdef BSG_MUL_RV_WORD_EN
  assign mulw_in = word_i & (op_i == 2'b00);
`else
  assign mulw_in = 1'b0;
`endif
  assign v_o                 = (state_q == eDone);
  assign result_o            = result_q;
  assign mul_if.mul_v_o      = (state_q == eIssue);
  assign mul_if.mul_opA_o    = opA_q;
  assign mul_if.mul_opB_o    = opB_q;
  assign mul_if.mul_signed_o = (op_q == 2'b01);
  assign mul_if.mul_yumi_o   = mul_if.mul_v_i & (state_q == eIdle || state_q == eWait);
  // next-state, operand latch, product capture and MULHSU correction
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    mulw_d   = mulw_q;
    result_d = result_q;
    ready_o  = 1'b0;
    case (state_q)
      eIdle: begin
        ready_o = mul_if.mul_ready_i & ~mul_if.mul_v_i;
        if (v_i & ready_o) begin
          op_d    = op_i;
          opA_d   = mulw_in ? {{(width_p-32){opA_i[31]}}, opA_i[31:0]} : opA_i;
          opB_d   = mulw_in ? {{(width_p-32){opB_i[31]}}, opB_i[31:0]} : opB_i;
          mulw_d  = mulw_in;
          state_d = eIssue;
        end
      end
      eIssue: state_d = mul_if.mul_ready_i ? eWait : eIssue;
      eWait: if (mul_if.mul_v_i) begin
        result_d = (op_q != 2'b00) ? mul_if.mul_result_i[2*width_p-1:width_p]
                 : mulw_q ? {{(width_p-32){mul_if.mul_result_i[31]}}, mul_if.mul_result_i[31:0]}
                 : mul_if.mul_result_i[width_p-1:0];
        state_d  = (op_q == 2'b10 && opA_q[width_p-1]) ? eFix : eDone;
      end
      eFix: begin
        result_d = result_q - opB_q;
        state_d  = eDone;
      end
      eDone: state_d = yumi_i ? eIdle : eDone;
      default: state_d = eIdle;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      op_q     <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      mulw_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      mulw_q   <= mulw_d;
      result_q <= result_d;
    end
  end
  // consuming a result that is not being offered is a client protocol error
  always @(posedge clk_i) begin
    if (reset_n_i) assert (!yumi_i || v_o);
  end
endmodule
